// File: rtl/serial_rx_pkg.sv
// Shared types and line-level constants for the serial frame receiver.
// The PARITY and PERR states exist only when SERIAL_RX_PARITY_EN is defined.
// Encodings are fixed so state values look the same in both builds.
package serial_rx_pkg;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_LVL = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DATA   = 3'd1,
`ifdef SERIAL_RX_PARITY_EN
        ST_PARITY = 3'd2,
`endif
        ST_STOP   = 3'd3,
        ST_DONE   = 3'd4,
`ifdef SERIAL_RX_PARITY_EN
        ST_PERR   = 3'd5,
`endif
        ST_FERR   = 3'd6,
        ST_FWAIT  = 3'd7
    } serial_rx_state_t;

endpackage

// File: rtl/serial_rx_shift.sv
// Datapath for the serial receiver: shift register, bit counter and the
// serially accumulated parity bit.
// Optional feature: SERIAL_RX_PARITY_EN keeps the parity accumulator.
// Ports:
//   clk, reset    - clock, synchronous active-high reset
//   clr           - start of a frame: clear counter, word and parity
//   shift_en      - store `in` at position cnt and advance cnt
//   par_cap       - fold the received parity bit into the accumulator
//   in            - serial line
//   word          - assembled data word (bit 0 = first bit received)
//   last_bit_c    - counter points at the final data bit
//   parity_ok_c   - accumulated parity matches the configured sense
module serial_rx_shift #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clr,
    input  logic                 shift_en,
    input  logic                 par_cap,
    input  logic                 in,
    output logic [DATA_BITS-1:0] word,
    output logic                 last_bit_c,
    output logic                 parity_ok_c
);

    localparam int unsigned CNT_W = $clog2(DATA_BITS);

    logic [DATA_BITS-1:0] word_q, word_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    // Bit-indexed capture; the counter is cleared at every start bit.
    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        if (clr) begin
            word_d = '0;
            cnt_d  = '0;
        end else if (shift_en) begin
            word_d[cnt_q] = in;
            cnt_d         = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

    assign word       = word_q;
    assign last_bit_c = (cnt_q == CNT_W'(DATA_BITS - 1));

`ifdef SERIAL_RX_PARITY_EN
    logic par_q, par_d;

    // Running XOR of every data bit and the parity bit.
    always_comb begin
        par_d = par_q;
        if (clr) begin
            par_d = 1'b0;
        end else if (shift_en || par_cap) begin
            par_d = par_q ^ in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end

    assign parity_ok_c = (par_q == 1'(PARITY_ODD));
`else
    logic unused_par_cfg;

    assign unused_par_cfg = par_cap ^ 1'(PARITY_ODD);
    assign parity_ok_c    = 1'b1;
`endif

endmodule

// File: rtl/serial_rx_frame.sv
// Serial frame receiver: start bit, DATA_BITS data bits LSB-first, optional
// parity bit, stop bit. One bit per clock, back-to-back frames supported.
// Optional feature: SERIAL_RX_PARITY_EN adds the parity bit and parity_err.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   in          - serial line, idle high
//   done        - one-cycle pulse for a good frame
//   out_data    - data of the last good frame
//   frame_err   - one-cycle pulse when the stop bit reads 0
//   parity_err  - one-cycle pulse on a parity mismatch with a good stop bit
module serial_rx_frame
    import serial_rx_pkg::*;
#(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in,
    output logic                 done,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 frame_err,
    output logic                 parity_err
);

    serial_rx_state_t state_q, state_d;

    logic                 clr_c;
    logic                 shift_en_c;
    logic                 par_cap_c;
    logic [DATA_BITS-1:0] word;
    logic                 last_bit_c;
    logic                 parity_ok_c;

    logic                 done_q, done_d;
    logic                 frame_err_q, frame_err_d;
    logic                 parity_err_q, parity_err_d;
    logic [DATA_BITS-1:0] out_data_q, out_data_d;

    serial_rx_shift #(
        .DATA_BITS  (DATA_BITS),
        .PARITY_ODD (PARITY_ODD)
    ) u_shift (
        .clk         (clk),
        .reset       (reset),
        .clr         (clr_c),
        .shift_en    (shift_en_c),
        .par_cap     (par_cap_c),
        .in          (in),
        .word        (word),
        .last_bit_c  (last_bit_c),
        .parity_ok_c (parity_ok_c)
    );

`ifndef SERIAL_RX_PARITY_EN
    logic unused_parity_ok;
    assign unused_parity_ok = parity_ok_c;
`endif

    // Next-state and datapath control.
    always_comb begin
        state_d    = state_q;
        clr_c      = 1'b0;
        shift_en_c = 1'b0;
        par_cap_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in == START_LVL) begin
                    state_d = ST_DATA;
                    clr_c   = 1'b1;
                end
            end
            ST_DATA: begin
                shift_en_c = 1'b1;
                if (last_bit_c) begin
`ifdef SERIAL_RX_PARITY_EN
                    state_d = ST_PARITY;
`else
                    state_d = ST_STOP;
`endif
                end
            end
`ifdef SERIAL_RX_PARITY_EN
            ST_PARITY: begin
                par_cap_c = 1'b1;
                state_d   = ST_STOP;
            end
`endif
            ST_STOP: begin
                if (in == LINE_IDLE) begin
`ifdef SERIAL_RX_PARITY_EN
                    state_d = parity_ok_c ? ST_DONE : ST_PERR;
`else
                    state_d = ST_DONE;
`endif
                end else begin
                    state_d = ST_FERR;
                end
            end
            // A start bit in the result cycle begins the next frame directly.
            ST_DONE: begin
                if (in == START_LVL) begin
                    state_d = ST_DATA;
                    clr_c   = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
`ifdef SERIAL_RX_PARITY_EN
            ST_PERR: begin
                if (in == START_LVL) begin
                    state_d = ST_DATA;
                    clr_c   = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
`endif
            ST_FERR: begin
                state_d = (in == LINE_IDLE) ? ST_IDLE : ST_FWAIT;
            end
            // Swallow a stuck-low line so it reports only one frame error.
            ST_FWAIT: begin
                if (in == LINE_IDLE) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registered Moore outputs, decoded from the state being entered.
    always_comb begin
        done_d       = (state_d == ST_DONE);
        frame_err_d  = (state_d == ST_FERR);
`ifdef SERIAL_RX_PARITY_EN
        parity_err_d = (state_d == ST_PERR);
`else
        parity_err_d = 1'b0;
`endif
        out_data_d   = out_data_q;
        if (state_d == ST_DONE) begin
            out_data_d = word;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            done_q       <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            out_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            done_q       <= done_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            out_data_q   <= out_data_d;
        end
    end

    assign done       = done_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign out_data   = out_data_q;

endmodule

// File: tb/tb_serial_rx_frame.sv
// Directed bench for serial_rx_frame with DATA_BITS=8. Each frame pushes its
// expected result pulse, data and cycle onto a queue; a monitor pops and
// compares whenever an output pulse appears. Parity scenarios are built only
// when SERIAL_RX_PARITY_EN is defined.
module tb_serial_rx_frame;

    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned PARITY_ODD = 0;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 in;
    logic                 done;
    logic [DATA_BITS-1:0] out_data;
    logic                 frame_err;
    logic                 parity_err;

    typedef struct {
        logic [2:0] pulses;   // {parity_err, frame_err, done}
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;
    logic [7:0] last_good = 8'h00;

    serial_rx_frame #(
        .DATA_BITS  (DATA_BITS),
        .PARITY_ODD (PARITY_ODD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in         (in),
        .done       (done),
        .out_data   (out_data),
        .frame_err  (frame_err),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic good_par(input logic [7:0] d);
        return (^d) ^ 1'(PARITY_ODD);
    endfunction

    task automatic drive(input logic b);
        @(negedge clk);
        in = b;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b1);
    endtask

    // Sends one frame and records what the receiver must report for it.
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic pbit);
        exp_t e;
        logic p_bad;
        drive(1'b0);
        for (int i = 0; i < 8; i++) drive(d[i]);
`ifdef SERIAL_RX_PARITY_EN
        drive(pbit);
        p_bad = (^d) ^ pbit ^ 1'(PARITY_ODD);
`else
        p_bad = pbit & 1'b0;
`endif
        drive(stop);
        e.cyc = cyc + 1;
        if (!stop) begin
            e.pulses = 3'b010;
            e.data   = last_good;
        end else if (p_bad) begin
            e.pulses = 3'b100;
            e.data   = last_good;
        end else begin
            e.pulses  = 3'b001;
            e.data    = d;
            last_good = d;
        end
        exp_q.push_back(e);
    endtask

    // Every result pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done || frame_err || parity_err) begin
            chk("pulse_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                chk("pulse_kind", 32'({parity_err, frame_err, done}), 32'(mon_e.pulses));
                chk("pulse_data", 32'(out_data), 32'(mon_e.data));
                chk("pulse_cycle", 32'(cyc), 32'(mon_e.cyc));
            end
        end
    end

    initial begin
        logic [7:0] rnd;
        reset = 1'b1;
        in    = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_frame_err", 32'(frame_err), 32'd0);
        chk("reset_parity_err", 32'(parity_err), 32'd0);
        chk("reset_out_data", 32'(out_data), 32'd0);
        reset = 1'b0;

        idle(20);
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_frame_err", 32'(frame_err), 32'd0);
        chk("idle_parity_err", 32'(parity_err), 32'd0);
        chk("idle_out_data", 32'(out_data), 32'd0);

        send_frame(8'hA5, 1'b1, good_par(8'hA5));
        idle(3);
        chk("hold_a5", 32'(out_data), 32'hA5);

        // Second start bit lands in the DONE cycle of the first frame.
        send_frame(8'h3C, 1'b1, good_par(8'h3C));
        send_frame(8'hC3, 1'b1, good_par(8'hC3));
        idle(3);
        chk("hold_c3", 32'(out_data), 32'hC3);

        send_frame(8'h55, 1'b0, good_par(8'h55));
        repeat (5) drive(1'b0);
        idle(2);
        chk("ferr_keeps_data", 32'(out_data), 32'hC3);
        send_frame(8'h01, 1'b1, good_par(8'h01));
        idle(3);

`ifdef SERIAL_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1);
        idle(2);
        send_frame(8'h07, 1'b1, 1'b0);
        idle(3);
        chk("perr_keeps_data", 32'(out_data), 32'h07);
`endif

        // Abandon a frame with reset while data bit 4 is on the line.
        drive(1'b0);
        for (int i = 0; i < 4; i++) drive(1'(i & 1));
        @(negedge clk);
        reset = 1'b1;
        in    = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("abort_pulses", 32'({parity_err, frame_err, done}), 32'd0);
        chk("abort_out_data", 32'(out_data), 32'd0);
        reset     = 1'b0;
        last_good = 8'h00;
        idle(2);
        send_frame(8'h81, 1'b1, good_par(8'h81));
        idle(3);

        for (int k = 0; k < 4; k++) begin
            rnd = 8'($urandom_range(0, 255));
            send_frame(rnd, 1'b1, good_par(rnd));
        end
        idle(3);

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
